// File: rtl/timer_pkg.sv
// Shared constants and FSM state type for the timer scheduler.
// Default sizes plus the IDLE/ISSUE/WAIT/GAP state encoding.
package timer_pkg;

  localparam int N             = 10;
  localparam int DEPTH_DEF     = 4;
  localparam int START_LEN_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/timer_scheduler_if.sv
// Bus between controlling logic / timer and the scheduler.
// master: controller+timer side; slave: scheduler side.
interface timer_scheduler_if #(
  parameter int N = timer_pkg::N
);

  logic         push;
  logic [N-1:0] push_load;
  logic [N-1:0] push_end;
  logic         flush;
  logic         full;
  logic         empty;
  logic         start;
  logic [N-1:0] load_Val;
  logic [N-1:0] end_val;
  logic         done;
  logic         busy;
  logic         intv_done;
  logic         all_done;
  logic [7:0]   done_cnt;

  modport master (
    output push, push_load, push_end,
    output flush, done,
    input  full, empty, start,
    input  load_Val, end_val,
    input  busy, intv_done, all_done,
    input  done_cnt
  );

  modport slave (
    input  push, push_load, push_end,
    input  flush, done,
    output full, empty, start,
    output load_Val, end_val,
    output busy, intv_done, all_done,
    output done_cnt
  );

endinterface

// File: rtl/interval_fifo.sv
// Show-ahead FIFO of packed {load,end} pairs.
// Ports: clk, rst, i_push/i_data, i_pop, i_flush, o_data, o_full, o_empty.
module interval_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  // full is judged before any same-cycle pop
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = r_cnt[AW];
  assign o_empty = (r_cnt == '0);
  assign o_data  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Issues queued (load,end) pairs to a timer, one per done edge.
// Ports: clk, rst (sync, active high), bus (slave modport).
module timer_scheduler #(
  parameter int N         = timer_pkg::N,
  parameter int DEPTH     = timer_pkg::DEPTH_DEF,
  parameter int START_LEN = timer_pkg::START_LEN_DEF
) (
  input logic          clk,
  input logic          rst,
  timer_scheduler_if.slave bus
);

  import timer_pkg::*;

  localparam int CW = $clog2(START_LEN + 1);

  logic [2*N-1:0] w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_pop;
  logic           w_done_rise;

  state_t         r_state;
  state_t         w_state_nx;
  logic [CW-1:0]  r_scnt;
  logic [CW-1:0]  w_scnt_nx;
  logic           r_done_q;
  logic           r_start;
  logic           w_start_nx;
  logic [N-1:0]   r_load;
  logic [N-1:0]   w_load_nx;
  logic [N-1:0]   r_end;
  logic [N-1:0]   w_end_nx;
  logic           r_busy;
  logic           r_intv;
  logic           w_intv_nx;
  logic           r_all;
  logic           w_all_nx;
  logic [7:0]     r_cnt;
  logic [7:0]     w_cnt_nx;

  interval_fifo #(
    .W     (2*N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.push),
    .i_data  ({bus.push_load, bus.push_end}),
    .i_pop   (w_pop),
    .i_flush (bus.flush),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_done_rise   = bus.done & ~r_done_q;

  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.start     = r_start;
  assign bus.load_Val  = r_load;
  assign bus.end_val   = r_end;
  assign bus.busy      = r_busy;
  assign bus.intv_done = r_intv;
  assign bus.all_done  = r_all;
  assign bus.done_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_scnt   <= '0;
      r_done_q <= 1'b0;
      r_start  <= 1'b0;
      r_load   <= '0;
      r_end    <= '0;
      r_busy   <= 1'b0;
      r_intv   <= 1'b0;
      r_all    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_scnt   <= w_scnt_nx;
      r_done_q <= bus.done;
      r_start  <= w_start_nx;
      r_load   <= w_load_nx;
      r_end    <= w_end_nx;
      r_busy   <= (w_state_nx != IDLE);
      r_intv   <= w_intv_nx;
      r_all    <= w_all_nx;
      r_cnt    <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_scnt_nx  = r_scnt;
    w_start_nx = r_start;
    w_load_nx  = r_load;
    w_end_nx   = r_end;
    w_intv_nx  = 1'b0;
    w_all_nx   = 1'b0;
    w_cnt_nx   = r_cnt;
    w_pop      = 1'b0;
    if (bus.flush) begin
      w_state_nx = IDLE;
      w_start_nx = 1'b0;
      w_load_nx  = '0;
      w_end_nx   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_load_nx  = w_head[2*N-1:N];
            w_end_nx   = w_head[N-1:0];
            w_start_nx = 1'b1;
            w_scnt_nx  = CW'(START_LEN);
            w_state_nx = ISSUE;
          end
        end
        ISSUE: begin
          if (w_done_rise) begin
            w_start_nx = 1'b0;
            w_state_nx = GAP;
          end else if (r_scnt == CW'(1)) begin
            w_start_nx = 1'b0;
            w_state_nx = WAIT;
          end else begin
            w_scnt_nx = r_scnt - CW'(1);
          end
        end
        WAIT: begin
          if (w_done_rise) begin
            w_intv_nx  = 1'b1;
            w_cnt_nx   = r_cnt + 8'd1;
            w_state_nx = GAP;
          end
        end
        GAP: begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_load_nx  = w_head[2*N-1:N];
            w_end_nx   = w_head[N-1:0];
            w_start_nx = 1'b1;
            w_scnt_nx  = CW'(START_LEN);
            w_state_nx = ISSUE;
          end else begin
            w_all_nx   = 1'b1;
            w_state_nx = IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler.
// Vector table per cycle plus hand sequences for drain and reset.
module tb_timer_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  timer_scheduler_if #(.N(10)) bus ();

  timer_scheduler #(
    .N         (10),
    .DEPTH     (4),
    .START_LEN (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       push;
    logic [9:0] pl;
    logic [9:0] pe;
    logic       done;
    logic       flush;
    logic       s;
    logic [9:0] ld;
    logic [9:0] ed;
    logic       b;
    logic       i;
    logic       a;
    logic [7:0] c;
    logic       e;
    logic       f;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input int rs, input int pu, input int pl, input int pe,
    input int dn, input int fl, input int s, input int ld,
    input int ed, input int b, input int i, input int a,
    input int c, input int e, input int f
  );
    vec_t v;
    v.rst = rs[0]; v.push = pu[0];
    v.pl = pl[9:0]; v.pe = pe[9:0];
    v.done = dn[0]; v.flush = fl[0];
    v.s = s[0]; v.ld = ld[9:0]; v.ed = ed[9:0];
    v.b = b[0]; v.i = i[0]; v.a = a[0];
    v.c = c[7:0]; v.e = e[0]; v.f = f[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic p, input int pl, input int pe,
                       input logic d, input logic fl);
    bus.push      = p;
    bus.push_load = pl[9:0];
    bus.push_end  = pe[9:0];
    bus.done      = d;
    bus.flush     = fl;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);

    // single interval
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0,1,0));
    tbl.push_back(mk(0,1,7,2,0,0, 0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,7,2,1,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,7,2,1,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,7,2,1,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,7,2,1,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,7,2,1,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0,7,2,1,1,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0,7,2,0,0,1,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,7,2,0,0,0,1,1,0));
    // two queued intervals
    tbl.push_back(mk(0,1,7,2,0,0, 0,7,2,0,0,0,1,0,0));
    tbl.push_back(mk(0,1,5,1,0,0, 1,7,2,1,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,7,2,1,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,7,2,1,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0,7,2,1,1,0,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,5,1,1,0,0,2,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,5,1,1,0,0,2,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,5,1,1,0,0,2,1,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0,5,1,1,1,0,3,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,5,1,0,0,1,3,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,5,1,0,0,0,3,1,0));
    // done held high across GAP into next issue
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0,0,1,0));
    tbl.push_back(mk(0,1,3,4,0,0, 0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,6,8,0,0, 1,3,4,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,3,4,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,3,4,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0,3,4,1,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 1,6,8,1,0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,1,0, 1,6,8,1,0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0,6,8,1,0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0,6,8,1,0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,6,8,1,0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0,6,8,1,1,0,2,1,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0,6,8,0,0,1,2,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,6,8,0,0,0,2,1,0));
    // flush mid-WAIT with two queued, push in flush cycle dropped
    tbl.push_back(mk(0,1,1,2,0,0, 0,6,8,0,0,0,2,0,0));
    tbl.push_back(mk(0,1,3,4,0,0, 1,1,2,1,0,0,2,0,0));
    tbl.push_back(mk(0,1,5,6,0,0, 1,1,2,1,0,0,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,1,2,1,0,0,2,0,0));
    tbl.push_back(mk(0,1,7,7,0,1, 0,0,0,0,0,0,2,1,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,0,2,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,2,1,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,0,2,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,2,1,0));

    foreach (tbl[r]) begin
      rst = tbl[r].rst;
      drive(tbl[r].push, int'(tbl[r].pl), int'(tbl[r].pe),
            tbl[r].done, tbl[r].flush);
      @(negedge clk);
      chk($sformatf("r%0d.start", r), 32'(bus.start), 32'(tbl[r].s));
      chk($sformatf("r%0d.load", r), 32'(bus.load_Val), 32'(tbl[r].ld));
      chk($sformatf("r%0d.end", r), 32'(bus.end_val), 32'(tbl[r].ed));
      chk($sformatf("r%0d.busy", r), 32'(bus.busy), 32'(tbl[r].b));
      chk($sformatf("r%0d.intv", r), 32'(bus.intv_done), 32'(tbl[r].i));
      chk($sformatf("r%0d.all", r), 32'(bus.all_done), 32'(tbl[r].a));
      chk($sformatf("r%0d.cnt", r), 32'(bus.done_cnt), 32'(tbl[r].c));
      chk($sformatf("r%0d.empty", r), 32'(bus.empty), 32'(tbl[r].e));
      chk($sformatf("r%0d.full", r), 32'(bus.full), 32'(tbl[r].f));
    end

    // full FIFO: one interval in flight, then 5 pushes
    rst = 1'b0;
    drive(1'b1, 10, 1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("full.inwait.busy", 32'(bus.busy), 32'd1);
    chk("full.inwait.start", 32'(bus.start), 32'd0);
    for (int p = 0; p < 5; p++) begin
      drive(1'b1, 20 + p, p, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("full.p%0d", p), 32'(bus.full),
          (p >= 3) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    chk("full.empty", 32'(bus.empty), 32'd0);
    begin
      int   n_intv;
      int   n_all;
      int   k;
      logic prev_s;
      bit   ok;
      int   exp_ld [4];
      n_intv = 0; n_all = 0; k = 0;
      prev_s = 1'b0; ok = 1'b0;
      for (int q = 0; q < 4; q++) exp_ld[q] = 20 + q;
      for (int cyc = 0; cyc < 200; cyc++) begin
        if (bus.intv_done) bus.done = 1'b0;
        else if (bus.busy && !bus.start && !bus.done) bus.done = 1'b1;
        else bus.done = 1'b0;
        @(negedge clk);
        if (bus.intv_done) n_intv++;
        if (bus.start && !prev_s) begin
          if (k < 4)
            chk($sformatf("drain.load%0d", k),
                32'(bus.load_Val), 32'(exp_ld[k]));
          k++;
        end
        prev_s = bus.start;
        if (bus.all_done) begin
          n_all++;
          ok = 1'b1;
          break;
        end
      end
      bus.done = 1'b0;
      chk("drain.timeout", 32'(ok), 32'd1);
      chk("drain.issues", 32'(k), 32'd4);
      chk("drain.intv", 32'(n_intv), 32'd5);
      chk("drain.all", 32'(n_all), 32'd1);
      chk("drain.cnt", 32'(bus.done_cnt), 32'd7);
      chk("drain.busy", 32'(bus.busy), 32'd0);
      chk("drain.empty", 32'(bus.empty), 32'd1);
    end

    // reset mid-ISSUE with one entry still queued
    @(negedge clk);
    drive(1'b1, 1, 1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 2, 2, 1'b0, 1'b0);
    @(negedge clk);
    chk("rsti.start", 32'(bus.start), 32'd1);
    chk("rsti.empty", 32'(bus.empty), 32'd0);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst.start", 32'(bus.start), 32'd0);
    chk("rst.load", 32'(bus.load_Val), 32'd0);
    chk("rst.end", 32'(bus.end_val), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.intv", 32'(bus.intv_done), 32'd0);
    chk("rst.all", 32'(bus.all_done), 32'd0);
    chk("rst.cnt", 32'(bus.done_cnt), 32'd0);
    chk("rst.empty", 32'(bus.empty), 32'd1);
    chk("rst.full", 32'(bus.full), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post.start", 32'(bus.start), 32'd0);
    chk("post.busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
